// File: rtl/datamem_arbiter.sv
// ---------------------------------------------------------------------------
// datamem_arbiter
//
// Two-port arbiter/sequencer in front of a single-port data memory.
// Port 0 is the core load/store unit, port 1 a secondary master (DMA/debug).
// An accepted request is latched, presented to the memory for exactly one
// cycle, and answered with a registered one-cycle response pulse. Requests
// that are misaligned or use the illegal width code are answered with an
// error and never reach the memory. A starvation counter forces a grant to
// port 1 after it has been denied STARVE_LIMIT consecutive cycles.
//
// Ports
//   clk, reset_n            clock / asynchronous active-low reset
//   pN_valid/pN_ready       request handshake (N = 0, 1), ready only in IDLE
//   pN_we, pN_width         1=store; width 00 word, 10 half, 01 byte, 11 illegal
//   pN_addr, pN_wdata       byte address, right-aligned store data
//   pN_rvalid, pN_rdata     one-cycle response pulse and load data
//   pN_err                  misaligned / illegal width, valid with pN_rvalid
//   mem_we/width/addr/wdata memory request, driven only in the BUSY cycle
//   mem_rd                  combinational read data from the memory
// ---------------------------------------------------------------------------
module datamem_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             p0_valid,
    output logic             p0_ready,
    input  logic             p0_we,
    input  logic [1:0]       p0_width,
    input  logic [WIDTH-1:0] p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    output logic             p0_rvalid,
    output logic [WIDTH-1:0] p0_rdata,
    output logic             p0_err,
    input  logic             p1_valid,
    output logic             p1_ready,
    input  logic             p1_we,
    input  logic [1:0]       p1_width,
    input  logic [WIDTH-1:0] p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    output logic             p1_rvalid,
    output logic [WIDTH-1:0] p1_rdata,
    output logic             p1_err,
    output logic             mem_we,
    output logic [1:0]       mem_width,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rd
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               gnt_q, gnt_d;
    logic               we_q, we_d;
    logic [1:0]         width_q, width_d;
    logic [WIDTH-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               err_q, err_d;
    logic               p0_rvalid_q, p0_rvalid_d;
    logic               p1_rvalid_q, p1_rvalid_d;
    logic [WIDTH-1:0]   p0_rdata_q, p0_rdata_d;
    logic [WIDTH-1:0]   p1_rdata_q, p1_rdata_d;
    logic               p0_err_q, p0_err_d;
    logic               p1_err_q, p1_err_d;

    logic               force_p1;
    logic               p0_ready_c, p1_ready_c;
    logic               sel_we;
    logic [1:0]         sel_width;
    logic [WIDTH-1:0]   sel_addr, sel_wdata;
    logic               sel_err;
    logic [WIDTH-1:0]   load_data;
    logic               busy;

    assign busy = (state_q == S_BUSY);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        we_d        = we_q;
        width_d     = width_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;
        p0_rdata_d  = '0;
        p1_rdata_d  = '0;
        p0_err_d    = 1'b0;
        p1_err_d    = 1'b0;

        // Port 1 overrides port 0 only once it has waited long enough.
        force_p1   = (cnt_q == CNT_W'(STARVE_LIMIT)) && p1_valid;
        // Gated by reset_n so ready is also low while reset is held.
        p0_ready_c = reset_n && !busy && p0_valid && !force_p1;
        p1_ready_c = reset_n && !busy && p1_valid && (force_p1 || !p0_valid);

        sel_we    = p1_ready_c ? p1_we    : p0_we;
        sel_width = p1_ready_c ? p1_width : p0_width;
        sel_addr  = p1_ready_c ? p1_addr  : p0_addr;
        sel_wdata = p1_ready_c ? p1_wdata : p0_wdata;
        sel_err   = (sel_width == 2'b11)
                 || (sel_width == 2'b00 && sel_addr[1:0] != 2'b00)
                 || (sel_width == 2'b10 && sel_addr[0]);

        load_data = (!we_q && !err_q) ? mem_rd : '0;

        case (state_q)
            S_IDLE: begin
                if (p0_ready_c || p1_ready_c) begin
                    state_d = S_BUSY;
                    gnt_d   = p1_ready_c;
                    we_d    = sel_we;
                    width_d = sel_width;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    err_d   = sel_err;
                end
            end
            S_BUSY: begin
                state_d = S_IDLE;
                // Response for the access in flight, seen by requester next cycle.
                if (gnt_q) begin
                    p1_rvalid_d = 1'b1;
                    p1_rdata_d  = load_data;
                    p1_err_d    = err_q;
                end else begin
                    p0_rvalid_d = 1'b1;
                    p0_rdata_d  = load_data;
                    p0_err_d    = err_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Counts every denied cycle, BUSY cycles included, saturating at the limit.
        if (p1_ready_c) begin
            cnt_d = '0;
        end else if (p1_valid && cnt_q != CNT_W'(STARVE_LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            width_q     <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            p0_err_q    <= 1'b0;
            p1_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            we_q        <= we_d;
            width_q     <= width_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            p0_err_q    <= p0_err_d;
            p1_err_q    <= p1_err_d;
        end
    end

    assign p0_ready  = p0_ready_c;
    assign p1_ready  = p1_ready_c;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign p0_err    = p0_err_q;
    assign p1_err    = p1_err_q;

    // Memory side is quiet outside BUSY and for rejected requests; since
    // state_q resets asynchronously, mem_we falls as soon as reset asserts.
    assign mem_we    = busy && we_q && !err_q;
    assign mem_width = (busy && !err_q) ? width_q : 2'b00;
    assign mem_addr  = (busy && !err_q) ? addr_q  : '0;
    assign mem_wdata = (busy && !err_q) ? wdata_q : '0;

endmodule

// File: tb/tb_datamem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_datamem_arbiter
//
// Bench for datamem_arbiter. A byte-array memory stands in for datamem and
// is driven by the DUT's mem_* port. A transaction-level reference (own byte
// memory, busy flag, starvation count, pending response) predicts ready,
// memory request and responses; one compare process checks them on every
// falling edge. Directed transactions pin the model with literal values.
// ---------------------------------------------------------------------------
module tb_datamem_arbiter;

    localparam int W     = 32;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          p0_valid, p0_ready, p0_we, p0_rvalid, p0_err;
    logic [1:0]    p0_width;
    logic [W-1:0]  p0_addr, p0_wdata, p0_rdata;
    logic          p1_valid, p1_ready, p1_we, p1_rvalid, p1_err;
    logic [1:0]    p1_width;
    logic [W-1:0]  p1_addr, p1_wdata, p1_rdata;
    logic          mem_we;
    logic [1:0]    mem_width;
    logic [W-1:0]  mem_addr, mem_wdata, mem_rd;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    int we_cnt  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (mem_we) we_cnt++;

    datamem_arbiter #(.WIDTH(W), .STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_width(p0_width),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_width(p1_width),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_width(mem_width), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rd(mem_rd)
    );

    // ---------------- stand-in datamem (little-endian bytes) ----------------
    logic [7:0] dmem [0:255];
    logic [7:0] ra;

    always_comb begin
        ra = mem_addr[7:0];
        case (mem_width)
            2'b00:   mem_rd = {dmem[ra + 8'd3], dmem[ra + 8'd2], dmem[ra + 8'd1], dmem[ra]};
            2'b10:   mem_rd = {16'h0, dmem[ra + 8'd1], dmem[ra]};
            2'b01:   mem_rd = {24'h0, dmem[ra]};
            default: mem_rd = '0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_we) begin
            dmem[mem_addr[7:0]] <= mem_wdata[7:0];
            if (mem_width != 2'b01) dmem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
            if (mem_width == 2'b00) begin
                dmem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
                dmem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    // ---------------- comparison helper ----------------
    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          we;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        int          port;
    } op_t;

    logic [7:0]  mmem [0:255];
    bit          m_busy  = 0;
    op_t         m_op;
    int          m_starve = 0;
    bit          r_pend  = 0;
    int          r_port  = 0;
    logic [31:0] r_data  = 0;
    bit          r_err   = 0;

    function automatic int nbytes(input logic [1:0] w);
        return (w == 2'b00) ? 4 : (w == 2'b10) ? 2 : 1;
    endfunction

    function automatic bit is_err(input logic [1:0] w, input logic [31:0] a);
        return (w == 2'b11) || (w == 2'b00 && a % 4 != 0) || (w == 2'b10 && a % 2 != 0);
    endfunction

    always @(negedge clk) begin
        bit exp_r0, exp_r1, force_p1;
        logic [66:0] exp_mem;
        if (!reset_n) begin
            check("reset_outputs",
                  {p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err, mem_we,
                   mem_width, p0_rdata | p1_rdata | mem_addr | mem_wdata},
                  '0);
            m_busy = 0; m_starve = 0; r_pend = 0;
        end else begin
            force_p1 = (m_starve == LIMIT) && p1_valid;
            exp_r0 = !m_busy && p0_valid && !force_p1;
            exp_r1 = !m_busy && p1_valid && (force_p1 || !p0_valid);
            check("ready", {p0_ready, p1_ready}, {exp_r0, exp_r1});

            exp_mem = (m_busy && !m_op.err) ? {m_op.we, m_op.width, m_op.addr, m_op.wdata} : '0;
            check("mem_req", {mem_we, mem_width, mem_addr, mem_wdata}, exp_mem);

            check("rvalid", {p0_rvalid, p1_rvalid}, {r_pend && r_port == 0, r_pend && r_port == 1});
            if (r_pend) begin
                if (r_port == 0) check("p0_resp", {p0_rdata, p0_err}, {r_data, r_err});
                else             check("p1_resp", {p1_rdata, p1_err}, {r_data, r_err});
            end

            // advance to the next cycle
            r_pend = m_busy;
            if (m_busy) begin
                r_port = m_op.port;
                r_err  = m_op.err;
                r_data = 0;
                if (!m_op.err) begin
                    for (int b = 0; b < nbytes(m_op.width); b++) begin
                        if (m_op.we) mmem[8'(m_op.addr + b)] = m_op.wdata[8*b +: 8];
                        else         r_data[8*b +: 8] = mmem[8'(m_op.addr + b)];
                    end
                end
            end
            m_busy = exp_r0 || exp_r1;
            if (exp_r1)      m_op = '{p1_we, p1_width, p1_addr, p1_wdata, is_err(p1_width, p1_addr), 1};
            else if (exp_r0) m_op = '{p0_we, p0_width, p0_addr, p0_wdata, is_err(p0_width, p0_addr), 0};
            if (exp_r1)        m_starve = 0;
            else if (p1_valid) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int port, input bit v, input bit we, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        if (port == 0) begin
            p0_valid = v; p0_we = we; p0_width = w; p0_addr = a; p0_wdata = d;
        end else begin
            p1_valid = v; p1_we = we; p1_width = w; p1_addr = a; p1_wdata = d;
        end
    endtask

    // One request from a port; returns the response and accept->rvalid latency.
    task automatic xact(input int port, input bit we, input logic [1:0] w,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output bit er, output int lat);
        bit got;
        int acc;
        step();
        drive(port, 1, we, w, a, d);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (port == 0) ? p0_ready : p1_ready;
        end
        check("xact_accept", {79'h0, got}, 80'h1);
        step();
        acc = cyc;
        // Scramble the requester fields: only the latched copy may be used.
        drive(port, 0, ~we, 2'b11, $urandom, $urandom);
        got = 0; rd = 0; er = 0; lat = -1;
        for (int i = 0; i < 6 && !got; i++) begin
            @(negedge clk);
            if ((port == 0) ? p0_rvalid : p1_rvalid) begin
                got = 1;
                rd  = (port == 0) ? p0_rdata : p1_rdata;
                er  = (port == 0) ? p0_err : p1_err;
                lat = cyc - acc;
            end
        end
        check("xact_rvalid_seen", {79'h0, got}, 80'h1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] rd;
        bit er, got;
        int lat, w0;
        logic [11:0] pat0, pat1;

        for (int i = 0; i < 256; i++) begin dmem[i] = 8'h0; mmem[i] = 8'h0; end
        reset_n = 0;
        drive(0, 0, 0, 2'b00, 0, 0);
        drive(1, 0, 0, 2'b00, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1;

        // word store then load on port 0
        w0 = we_cnt;
        xact(0, 1, 2'b00, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("st_word_resp", {rd, er, 32'(lat)}, {32'h0, 1'b0, 32'd1});
        check("st_word_we_cycles", 80'(we_cnt - w0), 80'd1);
        w0 = we_cnt;
        xact(0, 0, 2'b00, 32'h10, 32'h0, rd, er, lat);
        check("ld_word_resp", {rd, er, 32'(lat)}, {32'hDEADBEEF, 1'b0, 32'd1});
        check("ld_word_no_we", 80'(we_cnt - w0), 80'd0);

        // byte merge through port 1
        xact(1, 1, 2'b00, 32'h10, 32'h11223344, rd, er, lat);
        xact(1, 1, 2'b01, 32'h13, 32'h000000AB, rd, er, lat);
        xact(1, 0, 2'b00, 32'h10, 32'h0, rd, er, lat);
        check("byte_merge", {rd, er, 32'(lat)}, {32'hAB223344, 1'b0, 32'd1});
        xact(0, 0, 2'b10, 32'h12, 32'h0, rd, er, lat);
        check("ld_half_ok", {rd, er}, {32'h0000AB22, 1'b0});

        // rejected requests
        w0 = we_cnt;
        xact(0, 0, 2'b10, 32'h11, 32'h0, rd, er, lat);
        check("misaligned_half", {rd, er}, {32'h0, 1'b1});
        xact(0, 1, 2'b11, 32'h10, 32'hFFFFFFFF, rd, er, lat);
        check("illegal_width", {rd, er}, {32'h0, 1'b1});
        xact(1, 1, 2'b00, 32'h12, 32'hFFFFFFFF, rd, er, lat);
        check("misaligned_word", {rd, er}, {32'h0, 1'b1});
        check("errors_no_we", 80'(we_cnt - w0), 80'd0);

        // reset during a BUSY store drops it
        xact(0, 1, 2'b00, 32'h30, 32'h55AA55AA, rd, er, lat);
        step();
        drive(0, 1, 1, 2'b00, 32'h30, 32'hFFFFFFFF);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = p0_ready; end
        step();
        check("rst_busy_we", {79'h0, mem_we}, 80'h1);
        reset_n = 0;
        #1;
        check("rst_we_drop", {78'h0, mem_we, p0_ready}, 80'h0);
        p0_valid = 0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_rvalid", {78'h0, p0_rvalid, p1_rvalid}, 80'h0);
        end
        xact(0, 0, 2'b00, 32'h30, 32'h0, rd, er, lat);
        check("rst_word_kept", {rd, er}, {32'h55AA55AA, 1'b0});

        // starvation: both ports valid continuously from counter 0
        step();
        drive(0, 1, 0, 2'b00, 32'h20, 0);
        drive(1, 1, 0, 2'b00, 32'h24, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            pat0[i] = p0_ready;
            pat1[i] = p1_ready;
        end
        step();
        drive(0, 0, 0, 2'b00, 0, 0);
        drive(1, 0, 0, 2'b00, 0, 0);
        check("starve_p0_pattern", 80'(pat0), 80'h145);
        check("starve_p1_pattern", 80'(pat1), 80'h410);

        // randomized traffic, heavy contention
        for (int i = 0; i < 1500; i++) begin
            step();
            drive(0, $urandom_range(0, 2) != 0, 1'($urandom), 2'($urandom),
                  $urandom_range(0, 63), $urandom);
            drive(1, $urandom_range(0, 2) != 0, 1'($urandom), 2'($urandom),
                  $urandom_range(0, 63), $urandom);
        end
        step();
        drive(0, 0, 0, 2'b00, 0, 0);
        drive(1, 0, 0, 2'b00, 0, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
